// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: registered sync/DE/RGB, lead-time pixel
// requests with coordinates, frame/line strobes and a frame-aligned run enable.
module vga_timing_gen #(
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BACK   = 48,
   parameter int unsigned H_DISP   = 640,
   parameter int unsigned H_FRONT  = 16,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BACK   = 33,
   parameter int unsigned V_DISP   = 480,
   parameter int unsigned V_FRONT  = 10,
   parameter logic        HS_POL   = 1'b0,
   parameter logic        VS_POL   = 1'b0,
   parameter int unsigned RGB_W    = 12,
   parameter int unsigned CW       = 11,
   parameter int unsigned REQ_LEAD = 1
) (
   input  logic             vga_clk,
   input  logic             sys_rst_n,
   input  logic             en,
   input  logic [RGB_W-1:0] pixel_data,
   output logic             vga_hs,
   output logic             vga_vs,
   output logic             vga_de,
   output logic [RGB_W-1:0] vga_rgb,
   output logic             data_req,
   output logic [CW-1:0]    pixel_x,
   output logic [CW-1:0]    pixel_y,
   output logic             frame_start,
   output logic             line_start
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

   localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_SYNC_END = CW'(H_SYNC);
   localparam logic [CW-1:0] V_SYNC_END = CW'(V_SYNC);
   localparam logic [CW-1:0] H_ACT      = CW'(H_SYNC + H_BACK);
   localparam logic [CW-1:0] H_ACT_END  = CW'(H_SYNC + H_BACK + H_DISP);
   localparam logic [CW-1:0] V_ACT      = CW'(V_SYNC + V_BACK);
   localparam logic [CW-1:0] V_ACT_END  = CW'(V_SYNC + V_BACK + V_DISP);

   // One extra bit so h + REQ_LEAD cannot wrap near the end of a line
   localparam logic [CW:0]   LEAD_X     = (CW+1)'(REQ_LEAD);
   localparam logic [CW:0]   H_ACT_X    = {1'b0, H_ACT};
   localparam logic [CW:0]   H_ACT_END_X = {1'b0, H_ACT_END};

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   h_q, h_d;
   logic [CW-1:0]   v_q, v_d;

   logic             vga_hs_q, vga_hs_d;
   logic             vga_vs_q, vga_vs_d;
   logic             vga_de_q, vga_de_d;
   logic [RGB_W-1:0] vga_rgb_q, vga_rgb_d;
   logic             data_req_q, data_req_d;
   logic [CW-1:0]    pixel_x_q, pixel_x_d;
   logic [CW-1:0]    pixel_y_q, pixel_y_d;
   logic             frame_start_q, frame_start_d;
   logic             line_start_q, line_start_d;

   logic             run_d;
   logic             v_vis;
   logic             h_vis;
   logic             h_req;
   logic [CW:0]      h_lead;

   // Position sequencing; run state only changes at frame boundaries
   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      v_d     = v_q;
      case (state_q)
         ST_IDLE: begin
            if (en) begin
               state_d = ST_RUN;
               h_d     = '0;
               v_d     = '0;
            end
         end
         ST_RUN: begin
            if (h_q == H_LAST) begin
               h_d = '0;
               if (v_q == V_LAST) begin
                  v_d = '0;
                  if (!en) begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  v_d = v_q + CW'(1);
               end
            end else begin
               h_d = h_q + CW'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            h_d     = '0;
            v_d     = '0;
         end
      endcase
   end

   // Outputs are decoded from the next position so they land registered with it
   always_comb begin
      run_d         = (state_d == ST_RUN);
      h_lead        = {1'b0, h_d} + LEAD_X;
      v_vis         = (v_d >= V_ACT) && (v_d < V_ACT_END);
      h_vis         = (h_d >= H_ACT) && (h_d < H_ACT_END);
      h_req         = (h_lead >= H_ACT_X) && (h_lead < H_ACT_END_X);

      vga_hs_d      = ~HS_POL;
      vga_vs_d      = ~VS_POL;
      vga_de_d      = 1'b0;
      vga_rgb_d     = '0;
      data_req_d    = 1'b0;
      pixel_x_d     = '0;
      pixel_y_d     = '0;
      frame_start_d = 1'b0;
      line_start_d  = 1'b0;

      if (run_d) begin
         vga_hs_d      = (h_d < H_SYNC_END) ? HS_POL : ~HS_POL;
         vga_vs_d      = (v_d < V_SYNC_END) ? VS_POL : ~VS_POL;
         vga_de_d      = h_vis && v_vis;
         data_req_d    = h_req && v_vis;
         frame_start_d = (h_d == '0) && (v_d == '0);
         line_start_d  = (h_d == '0);
         if (vga_de_d) begin
            vga_rgb_d = pixel_data;
         end
         if (data_req_d) begin
            pixel_x_d = CW'(h_lead - H_ACT_X);
            pixel_y_d = v_d - V_ACT;
         end
      end
   end

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q       <= ST_IDLE;
         h_q           <= '0;
         v_q           <= '0;
         vga_hs_q      <= ~HS_POL;
         vga_vs_q      <= ~VS_POL;
         vga_de_q      <= 1'b0;
         vga_rgb_q     <= '0;
         data_req_q    <= 1'b0;
         pixel_x_q     <= '0;
         pixel_y_q     <= '0;
         frame_start_q <= 1'b0;
         line_start_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         h_q           <= h_d;
         v_q           <= v_d;
         vga_hs_q      <= vga_hs_d;
         vga_vs_q      <= vga_vs_d;
         vga_de_q      <= vga_de_d;
         vga_rgb_q     <= vga_rgb_d;
         data_req_q    <= data_req_d;
         pixel_x_q     <= pixel_x_d;
         pixel_y_q     <= pixel_y_d;
         frame_start_q <= frame_start_d;
         line_start_q  <= line_start_d;
      end
   end

   assign vga_hs      = vga_hs_q;
   assign vga_vs      = vga_vs_q;
   assign vga_de      = vga_de_q;
   assign vga_rgb     = vga_rgb_q;
   assign data_req    = data_req_q;
   assign pixel_x     = pixel_x_q;
   assign pixel_y     = pixel_y_q;
   assign frame_start = frame_start_q;
   assign line_start  = line_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised en/reset stimulus against a frame-position reference model;
// a latency-matched pixel source feeds a pattern that the scoreboard checks.
module tb_vga_timing_gen;

   localparam int HS = 4, HB = 3, HD = 8, HF = 2;
   localparam int VS = 1, VB = 2, VD = 4, VF = 1;
   localparam int HT = HS + HB + HD + HF;
   localparam int VT = VS + VB + VD + VF;
   localparam int HA = HS + HB;
   localparam int VA = VS + VB;
   localparam int L  = 3;
   localparam logic HSP = 1'b1;
   localparam logic VSP = 1'b0;
   localparam int NCYC = 6000;

   typedef struct packed {
      logic        hs;
      logic        vs;
      logic        de;
      logic [11:0] rgb;
      logic        req;
      logic [5:0]  px;
      logic [5:0]  py;
      logic        fs;
      logic        ls;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [11:0] pixel_data;
   logic        vga_hs, vga_vs, vga_de, data_req, frame_start, line_start;
   logic [11:0] vga_rgb;
   logic [5:0]  pixel_x, pixel_y;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   bit   started = 0;

   vga_timing_gen #(
      .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
      .HS_POL(HSP), .VS_POL(VSP), .RGB_W(12), .CW(6), .REQ_LEAD(L)
   ) dut (
      .vga_clk(clk), .sys_rst_n(rst_n), .en(en), .pixel_data(pixel_data),
      .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .vga_rgb(vga_rgb),
      .data_req(data_req), .pixel_x(pixel_x), .pixel_y(pixel_y),
      .frame_start(frame_start), .line_start(line_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Source returns {y[3:0], x[7:0]} L-1 cycles after the request; garbage otherwise
   logic [11:0] pipe [0:L-1];
   always @(posedge clk) begin
      pipe[0] <= data_req ? {pixel_y[3:0], 2'b00, pixel_x} : 12'($urandom);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
   end
   assign pixel_data = pipe[L-2];

   function automatic exp_t model_out(bit run, int h, int v);
      exp_t e;
      bit   vv;
      e    = '0;
      e.hs = ~HSP;
      e.vs = ~VSP;
      if (run) begin
         e.hs  = (h < HS) ? HSP : ~HSP;
         e.vs  = (v < VS) ? VSP : ~VSP;
         vv    = (v >= VA) && (v < VA + VD);
         e.de  = vv && (h >= HA) && (h < HA + HD);
         if (e.de) e.rgb = 12'(((v - VA) % 16) * 256 + (h - HA) % 256);
         e.req = vv && (h + L >= HA) && (h + L < HA + HD);
         if (e.req) begin
            e.px = 6'(h + L - HA);
            e.py = 6'(v - VA);
         end
         e.fs = (h == 0) && (v == 0);
         e.ls = (h == 0);
      end
      return e;
   endfunction

   task automatic compare(input string name, input exp_t e);
      exp_t a;
      a = '{hs: vga_hs, vs: vga_vs, de: vga_de, rgb: vga_rgb, req: data_req,
            px: pixel_x, py: pixel_y, fs: frame_start, ls: line_start};
      n_cmp++;
      if (a !== e) begin
         n_err++;
         $display("FAIL %s t=%0t got hs%b vs%b de%b rgb%h req%b x%0d y%0d fs%b ls%b want hs%b vs%b de%b rgb%h req%b x%0d y%0d fs%b ls%b",
                  name, $time, a.hs, a.vs, a.de, a.rgb, a.req, a.px, a.py, a.fs, a.ls,
                  e.hs, e.vs, e.de, e.rgb, e.req, e.px, e.py, e.fs, e.ls);
      end
   endtask

   // Monitor: one output per clock, compared against the oldest expectation
   always @(posedge clk) begin
      #1;
      if (started) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty t=%0t got nothing to compare want an expectation", $time);
         end else begin
            compare("cycle", exp_q.pop_front());
         end
      end
   end

   // Driver with the reference model: frame position as plain (h,v) integers
   bit run_m;
   int h_m, v_m;
   int hold;

   initial begin
      rst_n = 1'b0;
      en    = 1'b0;
      run_m = 0;
      h_m   = 0;
      v_m   = 0;
      hold  = 3;
      for (int i = 0; i < NCYC; i++) begin
         @(negedge clk);
         if (i == 0) begin
            #1 compare("reset_initial", model_out(0, 0, 0));
         end
         if (!rst_n) begin
            if (hold == 0) begin
               rst_n = 1'b1;
               en    = 1'b1;
            end else begin
               hold--;
            end
         end else if (i == 2500 || $urandom_range(0, 1499) == 0) begin
            rst_n = 1'b0;
            hold  = $urandom_range(0, 3);
            #1 compare("reset_async", model_out(0, 0, 0));
         end else if ($urandom_range(0, 199) == 0) begin
            en = ~en;
         end

         if (!rst_n) begin
            run_m = 0;
         end else if (!run_m) begin
            if (en) begin
               run_m = 1;
               h_m   = 0;
               v_m   = 0;
            end
         end else if (h_m == HT - 1 && v_m == VT - 1) begin
            if (en) begin
               h_m = 0;
               v_m = 0;
            end else begin
               run_m = 0;
            end
         end else if (h_m == HT - 1) begin
            h_m = 0;
            v_m++;
         end else begin
            h_m++;
         end
         exp_q.push_back(model_out(run_m, h_m, v_m));
         started = 1;
      end
      @(posedge clk);
      #2;
      started = 0;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain got %0d left want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator that replaces the fixed 640x480 driver for our display path. It supports any resolution, sync polarity and pixel-source latency. It issues registered HS/VS/DE/RGB outputs, a pixel request with coordinates issued REQ_LEAD cycles ahead, and frame/line start strobes. It also has a run enable that starts and stops only on frame boundaries. It sits between the clock/reset block and the background/sprite pixel generators.

Parameters:
H_SYNC, 96, horizontal sync width (clocks)
H_BACK, 48, horizontal back porch
H_DISP, 640, active pixels per line
H_FRONT, 16, horizontal front porch
V_SYNC, 2, vertical sync width (lines)
V_BACK, 33, vertical back porch
V_DISP, 480, active lines
V_FRONT, 10, vertical front porch
HS_POL, 0, active level of vga_hs during sync
VS_POL, 0, active level of vga_vs during sync
RGB_W, 12, pixel width (4+4+4)
CW, 11, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1
REQ_LEAD, 1, cycles from data_req to matching vga_de; legal range 1..4 and at most H_SYNC+H_BACK

Ports:
vga_clk  in  1  pixel clock
sys_rst_n  in  1  asynchronous reset, active-low
en  in  1  run enable, sampled at frame boundary
pixel_data  in  RGB_W  pixel colour for the outstanding request
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_de  out  1  active-video flag
vga_rgb  out  RGB_W  pixel output, 0 outside active video
data_req  out  1  pixel request, REQ_LEAD cycles before its vga_de
pixel_x  out  CW  column of requested pixel, 0..H_DISP-1
pixel_y  out  CW  row of requested pixel, 0..V_DISP-1
frame_start  out  1  one-cycle strobe at output position (0,0)
line_start  out  1  one-cycle strobe at output column 0 of every line

Behaviour:
- Totals: H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT; V_TOTAL is the same sum for the V parameters.
- Output position (h,v): h runs 0..H_TOTAL-1. At h=H_TOTAL-1, h wraps to 0 and v increments. At v=V_TOTAL-1 with h=H_TOTAL-1, v wraps to 0 (frame end).
- All outputs are registered and reflect the current output position.
- vga_hs = HS_POL when h<H_SYNC, else ~HS_POL. vga_vs = VS_POL when v<V_SYNC, else ~VS_POL.
- vga_de = 1 when H_SYNC+H_BACK <= h < H_SYNC+H_BACK+H_DISP and V_SYNC+V_BACK <= v < V_SYNC+V_BACK+V_DISP.
- data_req is high exactly REQ_LEAD cycles before each vga_de cycle. While it is high, pixel_x = h+REQ_LEAD-(H_SYNC+H_BACK) and pixel_y = v-(V_SYNC+V_BACK). Both coordinates are 0 while data_req is low.
- Requests never span a line; REQ_LEAD <= H_SYNC+H_BACK guarantees this.
- Source contract: the source holds pixel_data valid REQ_LEAD-1 cycles after the request cycle. The generator registers it into vga_rgb, where it appears in the vga_de cycle of that pixel. vga_rgb is forced to 0 whenever vga_de=0.
- frame_start = 1 when (h,v)=(0,0). line_start = 1 when h=0.
- States: IDLE and RUN.
  - IDLE: outputs hold their reset values, and the position is parked.
  - IDLE -> RUN when en=1 at a clock edge. That edge presents (0,0), with frame_start=1 and both syncs active.
  - RUN -> IDLE only when en=0 at the frame-end edge (h=H_TOTAL-1, v=V_TOTAL-1). Deasserting en mid-frame has no effect until frame end.
  - en=1 at frame end continues into (0,0) with no gap.
- Reset values (asynchronous, immediate, valid mid-frame): state IDLE, vga_hs=~HS_POL, vga_vs=~VS_POL, vga_de=0, vga_rgb=0, data_req=0, pixel_x=0, pixel_y=0, frame_start=0, line_start=0. No stray pulse is allowed on release.
- pixel_x and pixel_y are zero-extended to CW bits. Counter arithmetic is unsigned CW-bit with no overflow for legal parameters.

Test Plan:
1. Defaults, release reset with en=1 -> first edge has frame_start=1, vga_hs=0, vga_vs=0. hs is low for 96 of every 800 cycles. vs is low for 1600 of every 420000 cycles. line_start every 800 cycles.
2. Defaults, REQ_LEAD=2 -> first data_req at v=35, h=142 with pixel_x=0, pixel_y=0. vga_de rises at h=144. 640 requests per line, with last pixel_x=639. 480 active lines, with last pixel_y=479.
3. Latency-matched source returning pixel_data={pixel_y[3:0],pixel_x[7:0]}, run with REQ_LEAD=1 and REQ_LEAD=3 -> vga_rgb equals the pattern for the correct (x,y) on every vga_de cycle, and is 0 on all others.
4. Drop en at v=200 -> the frame completes to v=524, h=799, then the block enters IDLE (syncs inactive, no frame_start). Raise en after 1000 cycles -> the next edge gives frame_start=1.
5. Assert sys_rst_n=0 mid active line -> all outputs go to reset values before the next edge. After release with en=1, restart at (0,0).
6. Override HS_POL=1, VS_POL=1, H=4/2/8/2, V=1/1/4/1, REQ_LEAD=1 -> active-high sync pulses, 16-cycle lines, 112-cycle frames, 8x4 pixels per frame with data_req at h=5..12.
